// File: rtl/pep_mmacc_common_param_pkg.sv
// Shared constants and command type for the PEP mono-mult-accumulate GRAM arbitration path.
// Window lengths are counted in arbitration slots of GARB_SLOT_CYCLE cycles each.
package pep_mmacc_common_param_pkg;

  localparam int GRAM_NB         = 4;
  localparam int GRAM_ID_W       = $clog2(GRAM_NB);
  localparam int GARB_SLOT_CYCLE = 8;
  localparam int GLWE_SLOT_NB    = 3;
  localparam int FEED_ADD_SLOT   = 1;
  localparam int ACC_ADD_SLOT    = 1;
  localparam int GARB_CMD_W      = GRAM_ID_W + 1;

  localparam int SLOT_CNT_W   = $clog2(GARB_SLOT_CYCLE);
  localparam int WIN_SLOT_MAX = GLWE_SLOT_NB +
                                ((FEED_ADD_SLOT > ACC_ADD_SLOT) ? FEED_ADD_SLOT : ACC_ADD_SLOT);
  localparam int WIN_CNT_W    = $clog2(WIN_SLOT_MAX + 1);

  typedef struct packed {
    logic                 critical;
    logic [GRAM_ID_W-1:0] grid;
  } garb_cmd_t;

  // The enum value doubles as the bit index in a port's avail_1h pair
  typedef enum logic {
    SRC_FEED = 1'b0,
    SRC_ACC  = 1'b1
  } garb_src_e;

endpackage

// File: rtl/pep_mmacc_gram_arb_win.sv
// Remaining-slot counter for one GRAM port: tracks the current owner and how many
// slot boundaries remain before the port is released.
module pep_mmacc_gram_arb_win
  import pep_mmacc_common_param_pkg::*;
(
  input  logic                 clk,
  input  logic                 s_rst,
  input  logic                 boundary,
  input  logic                 load,
  input  garb_src_e            load_owner,
  input  logic [WIN_CNT_W-1:0] load_slot_nb,
  output logic [1:0]           avail_1h,
  output logic                 idle,
  output logic                 free_next
);

  logic [WIN_CNT_W-1:0] rem;
  logic [WIN_CNT_W-1:0] rem_nxt;
  garb_src_e            owner;
  garb_src_e            owner_nxt;
  logic [1:0]           avail_nxt;

  always_comb begin
    rem_nxt   = rem;
    owner_nxt = owner;
    if (load) begin
      rem_nxt   = load_slot_nb;
      owner_nxt = load_owner;
    end else if (boundary && (rem != '0)) begin
      rem_nxt = rem - WIN_CNT_W'(1);
    end
    avail_nxt = '0;
    if (rem_nxt != '0) avail_nxt = (owner_nxt == SRC_ACC) ? 2'b10 : 2'b01;
  end

  // Outputs are registered from next-state values so a window starts the cycle after loading
  always_ff @(posedge clk) begin
    if (s_rst) begin
      rem      <= '0;
      owner    <= SRC_FEED;
      avail_1h <= '0;
      idle     <= 1'b1;
    end else begin
      rem      <= rem_nxt;
      owner    <= owner_nxt;
      avail_1h <= avail_nxt;
      idle     <= (rem_nxt == '0);
    end
  end

  assign free_next = (rem <= WIN_CNT_W'(1));

endmodule

// File: rtl/pep_mmacc_gram_arbiter.sv
// Time-slotted GRAM arbiter: grants mmfeed/mmacc exclusive GRAM windows at slot boundaries
// and hands leftover port time to the loader (port A) and sample extractor (port B).
module pep_mmacc_gram_arbiter
  import pep_mmacc_common_param_pkg::*;
(
  input  logic                  clk,
  input  logic                  s_rst,
  input  logic [GARB_CMD_W-1:0] mmfeed_garb_req,
  input  logic                  mmfeed_garb_req_vld,
  output logic                  mmfeed_garb_req_rdy,
  input  logic [GARB_CMD_W-1:0] mmacc_garb_req,
  input  logic                  mmacc_garb_req_vld,
  output logic                  mmacc_garb_req_rdy,
  output logic                  garb_mmfeed_grant,
  output logic                  garb_mmacc_grant,
  output logic [GRAM_NB-1:0]    garb_mmfeed_rot_avail_1h,
  output logic [GRAM_NB-1:0]    garb_mmfeed_dat_avail_1h,
  output logic [GRAM_NB-1:0]    garb_mmacc_rd_avail_1h,
  output logic [GRAM_NB-1:0]    garb_mmacc_wr_avail_1h,
  output logic [GRAM_NB-1:0]    garb_mmsxt_avail_1h,
  output logic [GRAM_NB-1:0]    garb_ldg_avail_1h
);

  localparam logic [WIN_CNT_W-1:0] RD_SLOT_NB  = WIN_CNT_W'(GLWE_SLOT_NB);
  localparam logic [WIN_CNT_W-1:0] DAT_SLOT_NB = WIN_CNT_W'(GLWE_SLOT_NB + FEED_ADD_SLOT);
  localparam logic [WIN_CNT_W-1:0] WR_SLOT_NB  = WIN_CNT_W'(GLWE_SLOT_NB + ACC_ADD_SLOT);

  logic [SLOT_CNT_W-1:0] slot_cnt;
  logic                  boundary;
  garb_src_e             rr_prio;
  garb_cmd_t             feed_cmd;
  garb_cmd_t             acc_cmd;

  logic [1:0]         avail_a [GRAM_NB];
  logic [1:0]         avail_b [GRAM_NB];
  logic [GRAM_NB-1:0] idle_a, idle_b, free_a, free_b;
  logic [GRAM_NB-1:0] rot_1h, rd_1h, dat_1h, wr_1h;

  logic feed_own_free, acc_own_free;
  logic feed_elig, acc_elig, contest, acc_wins;

  assign feed_cmd = mmfeed_garb_req;
  assign acc_cmd  = mmacc_garb_req;
  assign boundary = (slot_cnt == SLOT_CNT_W'(GARB_SLOT_CYCLE - 1)) & ~s_rst;

  // A source may only start a new window once its current port-A window ends at this boundary
  assign feed_own_free = &(~rot_1h | free_a);
  assign acc_own_free  = &(~rd_1h | free_a);

  always_comb begin
    feed_elig = boundary & mmfeed_garb_req_vld & feed_own_free
              & free_a[feed_cmd.grid] & free_b[feed_cmd.grid];
    acc_elig  = boundary & mmacc_garb_req_vld & acc_own_free
              & free_a[acc_cmd.grid] & free_b[acc_cmd.grid];
    contest   = feed_elig & acc_elig & (feed_cmd.grid == acc_cmd.grid);
    acc_wins  = (rr_prio == SRC_ACC);
    if (feed_cmd.critical != acc_cmd.critical) acc_wins = acc_cmd.critical;
    mmfeed_garb_req_rdy = feed_elig & ~(contest & acc_wins);
    mmacc_garb_req_rdy  = acc_elig & ~(contest & ~acc_wins);
  end

  // Round-robin pointer favours whoever lost the most recent contest
  always_ff @(posedge clk) begin
    if (s_rst) begin
      slot_cnt          <= '0;
      rr_prio           <= SRC_FEED;
      garb_mmfeed_grant <= 1'b0;
      garb_mmacc_grant  <= 1'b0;
    end else begin
      slot_cnt          <= boundary ? '0 : slot_cnt + SLOT_CNT_W'(1);
      garb_mmfeed_grant <= mmfeed_garb_req_rdy;
      garb_mmacc_grant  <= mmacc_garb_req_rdy;
      if (contest) rr_prio <= acc_wins ? SRC_FEED : SRC_ACC;
    end
  end

  for (genvar g = 0; g < GRAM_NB; g++) begin : g_gram
    logic            hit_feed, hit_acc;
    garb_src_e       owner;
    logic [WIN_CNT_W-1:0] b_slot_nb;

    assign hit_feed  = mmfeed_garb_req_rdy & (feed_cmd.grid == GRAM_ID_W'(g));
    assign hit_acc   = mmacc_garb_req_rdy & (acc_cmd.grid == GRAM_ID_W'(g));
    assign owner     = hit_acc ? SRC_ACC : SRC_FEED;
    assign b_slot_nb = hit_acc ? WR_SLOT_NB : DAT_SLOT_NB;

    pep_mmacc_gram_arb_win u_port_a (
      .clk          (clk),
      .s_rst        (s_rst),
      .boundary     (boundary),
      .load         (hit_feed | hit_acc),
      .load_owner   (owner),
      .load_slot_nb (RD_SLOT_NB),
      .avail_1h     (avail_a[g]),
      .idle         (idle_a[g]),
      .free_next    (free_a[g])
    );

    pep_mmacc_gram_arb_win u_port_b (
      .clk          (clk),
      .s_rst        (s_rst),
      .boundary     (boundary),
      .load         (hit_feed | hit_acc),
      .load_owner   (owner),
      .load_slot_nb (b_slot_nb),
      .avail_1h     (avail_b[g]),
      .idle         (idle_b[g]),
      .free_next    (free_b[g])
    );

    assign rot_1h[g] = avail_a[g][SRC_FEED];
    assign rd_1h[g]  = avail_a[g][SRC_ACC];
    assign dat_1h[g] = avail_b[g][SRC_FEED];
    assign wr_1h[g]  = avail_b[g][SRC_ACC];
  end

  assign garb_mmfeed_rot_avail_1h = rot_1h;
  assign garb_mmfeed_dat_avail_1h = dat_1h;
  assign garb_mmacc_rd_avail_1h   = rd_1h;
  assign garb_mmacc_wr_avail_1h   = wr_1h;
  assign garb_ldg_avail_1h        = idle_a;
  assign garb_mmsxt_avail_1h      = idle_b;

endmodule

// File: tb/tb_pep_mmacc_gram_arbiter.sv
// Self-checking bench for pep_mmacc_gram_arbiter: boundary-cycle handshake vectors plus
// window-length, contention, back-to-back, reset and randomized-critical sequences.
module tb_pep_mmacc_gram_arbiter;
  import pep_mmacc_common_param_pkg::*;

  logic                  clk = 1'b0;
  logic                  s_rst;
  logic [GARB_CMD_W-1:0] fr, ar;
  logic                  fv, av;
  logic                  f_rdy, a_rdy, f_gnt, a_gnt;
  logic [GRAM_NB-1:0]    rot, dat, rd, wr, sxt, ldg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic mon_en = 1'b0;
  logic cnt_en = 1'b0;
  int feed_grants = 0;
  int acc_grants = 0;
  localparam int RND_N = 24;

  typedef struct {
    logic                  fv;
    logic [GARB_CMD_W-1:0] fr;
    logic                  av;
    logic [GARB_CMD_W-1:0] ar;
    logic                  efr;
    logic                  ear;
  } vec_t;

  vec_t vecs [8];

  pep_mmacc_gram_arbiter dut (
    .clk                      (clk),
    .s_rst                    (s_rst),
    .mmfeed_garb_req          (fr),
    .mmfeed_garb_req_vld      (fv),
    .mmfeed_garb_req_rdy      (f_rdy),
    .mmacc_garb_req           (ar),
    .mmacc_garb_req_vld       (av),
    .mmacc_garb_req_rdy       (a_rdy),
    .garb_mmfeed_grant        (f_gnt),
    .garb_mmacc_grant         (a_gnt),
    .garb_mmfeed_rot_avail_1h (rot),
    .garb_mmfeed_dat_avail_1h (dat),
    .garb_mmacc_rd_avail_1h   (rd),
    .garb_mmacc_wr_avail_1h   (wr),
    .garb_mmsxt_avail_1h      (sxt),
    .garb_ldg_avail_1h        (ldg)
  );

  always #5 clk = ~clk;

  // Bench copy of the slot position: cycles since reset release
  always @(posedge clk) begin
    if (s_rst) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Port ownership invariants hold every cycle
  logic [GRAM_NB-1:0] mon_ldg, mon_sxt;
  always @(negedge clk) begin
    if (mon_en) begin
      mon_ldg = ~(rot | rd);
      mon_sxt = ~(dat | wr);
      checkOutput("inv_ldg", ldg, mon_ldg);
      checkOutput("inv_sxt", sxt, mon_sxt);
      checkOutput("inv_rot_onehot0", $onehot0(rot), 1);
      checkOutput("inv_rd_onehot0", $onehot0(rd), 1);
      checkOutput("inv_a_excl", rot & rd, 0);
      checkOutput("inv_b_excl", dat & wr, 0);
    end
  end

  always @(negedge clk) begin
    if (cnt_en) begin
      if (f_gnt) feed_grants++;
      if (a_gnt) acc_grants++;
    end
  end

  task automatic doReset;
    s_rst = 1'b1;
    fv = 1'b0; av = 1'b0; fr = '0; ar = '0;
    repeat (2) @(posedge clk);
    #1 s_rst = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the edge that opens a boundary cycle
  task automatic goBoundary;
    while ((cyc % GARB_SLOT_CYCLE) != GARB_SLOT_CYCLE - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [GRAM_NB-1:0] e_f, e_a;
    e_f = v.efr ? (GRAM_NB'(1) << v.fr[GRAM_ID_W-1:0]) : '0;
    e_a = v.ear ? (GRAM_NB'(1) << v.ar[GRAM_ID_W-1:0]) : '0;
    doReset;
    @(negedge clk);
    checkOutput($sformatf("v%0d_rst_rot", idx), rot, 0);
    checkOutput($sformatf("v%0d_rst_wr", idx), wr, 0);
    checkOutput($sformatf("v%0d_rst_ldg", idx), ldg, 4'hF);
    checkOutput($sformatf("v%0d_rst_sxt", idx), sxt, 4'hF);
    checkOutput($sformatf("v%0d_rst_gnt", idx), {f_gnt, a_gnt}, 0);
    fv = v.fv; fr = v.fr; av = v.av; ar = v.ar;
    #1;
    checkOutput($sformatf("v%0d_rdy_off_boundary", idx), {f_rdy, a_rdy}, 0);
    @(posedge clk); #1;
    goBoundary;
    @(negedge clk);
    checkOutput($sformatf("v%0d_feed_rdy", idx), f_rdy, v.efr);
    checkOutput($sformatf("v%0d_acc_rdy", idx), a_rdy, v.ear);
    @(posedge clk); #1;
    fv = 1'b0; av = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("v%0d_feed_gnt", idx), f_gnt, v.efr);
    checkOutput($sformatf("v%0d_acc_gnt", idx), a_gnt, v.ear);
    checkOutput($sformatf("v%0d_rot", idx), rot, e_f);
    checkOutput($sformatf("v%0d_dat", idx), dat, e_f);
    checkOutput($sformatf("v%0d_rd", idx), rd, e_a);
    checkOutput($sformatf("v%0d_wr", idx), wr, e_a);
    @(posedge clk); #1;
  endtask

  initial begin
    int wf, wc;
    logic [GRAM_NB-1:0] e_dat;

    vecs[0] = '{1'b1, 3'b0_10, 1'b0, 3'b0_00, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 3'b0_00, 1'b1, 3'b0_11, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 3'b0_01, 1'b1, 3'b1_01, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 3'b1_01, 1'b1, 3'b0_01, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 3'b0_00, 1'b1, 3'b0_11, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 3'b0_10, 1'b1, 3'b0_10, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 3'b1_11, 1'b1, 3'b1_11, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 3'b0_01, 1'b0, 3'b0_10, 1'b0, 1'b0};

    doReset;
    mon_en = 1'b1;
    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Single feed window on GRAM 2: exact rot/dat lengths
    doReset;
    goBoundary;
    fv = 1'b1; fr = 3'b0_10;
    @(negedge clk);
    checkOutput("win_rdy", f_rdy, 1);
    @(posedge clk); #1;
    fv = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checkOutput($sformatf("win_gnt_%0d", i), f_gnt, (i == 0));
      checkOutput($sformatf("win_rot_%0d", i), rot, (i < 24) ? 4'b0100 : 4'b0000);
      checkOutput($sformatf("win_dat_%0d", i), dat, (i < 32) ? 4'b0100 : 4'b0000);
    end
    @(posedge clk); #1;

    // Critical acc beats feed on GRAM 1; feed waits until acc_wr ends four slots later
    doReset;
    goBoundary;
    fv = 1'b1; fr = 3'b0_01; av = 1'b1; ar = 3'b1_01;
    @(negedge clk);
    checkOutput("crit_feed_rdy0", f_rdy, 0);
    checkOutput("crit_acc_rdy0", a_rdy, 1);
    @(posedge clk); #1;
    av = 1'b0;
    @(negedge clk);
    checkOutput("crit_acc_gnt", a_gnt, 1);
    checkOutput("crit_acc_rd", rd, 4'b0010);
    @(posedge clk); #1;
    for (int k = 1; k <= 4; k++) begin
      goBoundary;
      @(negedge clk);
      checkOutput($sformatf("crit_feed_rdy%0d", k), f_rdy, (k == 4));
      @(posedge clk); #1;
    end
    fv = 1'b0;
    @(negedge clk);
    checkOutput("crit_feed_gnt", f_gnt, 1);
    checkOutput("crit_feed_rot", rot, 4'b0010);
    checkOutput("crit_acc_wr_done", wr, 4'b0000);
    @(posedge clk); #1;

    // Round-robin: first tie goes to feed, the next tie to acc
    doReset;
    goBoundary;
    fv = 1'b1; fr = 3'b0_01; av = 1'b1; ar = 3'b0_01;
    @(negedge clk);
    checkOutput("rr_feed_rdy0", f_rdy, 1);
    checkOutput("rr_acc_rdy0", a_rdy, 0);
    @(posedge clk); #1;
    for (int k = 1; k <= 4; k++) begin
      goBoundary;
      @(negedge clk);
      checkOutput($sformatf("rr_feed_rdy%0d", k), f_rdy, 0);
      checkOutput($sformatf("rr_acc_rdy%0d", k), a_rdy, (k == 4));
      @(posedge clk); #1;
    end
    fv = 1'b0; av = 1'b0;
    @(negedge clk);
    checkOutput("rr_acc_gnt", a_gnt, 1);
    checkOutput("rr_feed_gnt", f_gnt, 0);
    @(posedge clk); #1;

    // Back-to-back feed windows on GRAMs 0..3, re-requested 16 cycles after each grant
    doReset;
    fork
      begin
        for (int j = 0; j < GRAM_NB; j++) begin
          fv = 1'b1; fr = {1'b0, GRAM_ID_W'(j)};
          wf = 0;
          do begin
            @(negedge clk);
            wf++;
          end while (!f_rdy && wf < 100);
          if (!f_rdy) checkOutput("b2b_rdy_timeout", 0, 1);
          @(posedge clk); #1;
          fv = 1'b0;
          if (j < GRAM_NB - 1) begin
            repeat (16) @(posedge clk);
            #1;
          end
        end
      end
      begin
        wc = 0;
        @(negedge clk);
        while (!f_gnt && wc < 200) begin
          @(negedge clk);
          wc++;
        end
        checkOutput("b2b_first_gnt", f_gnt, 1);
        for (int i = 0; i < 104; i++) begin
          e_dat = '0;
          for (int j = 0; j < GRAM_NB; j++)
            if (i >= 24 * j && i < 24 * j + 32) e_dat[j] = 1'b1;
          checkOutput($sformatf("b2b_rot_%0d", i), rot, (i < 96) ? (GRAM_NB'(1) << (i / 24)) : '0);
          checkOutput($sformatf("b2b_dat_%0d", i), dat, e_dat);
          checkOutput($sformatf("b2b_gnt_%0d", i), f_gnt, (i % 24 == 0) && (i < 96));
          @(negedge clk);
        end
      end
    join
    @(posedge clk); #1;

    // Reset asserted mid-window clears everything on the next cycle
    doReset;
    goBoundary;
    fv = 1'b1; fr = 3'b0_10; av = 1'b1; ar = 3'b0_11;
    @(posedge clk); #1;
    fv = 1'b0; av = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    s_rst = 1'b1; fv = 1'b1; av = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("mid_rst_rot", rot, 0);
    checkOutput("mid_rst_dat", dat, 0);
    checkOutput("mid_rst_rd", rd, 0);
    checkOutput("mid_rst_wr", wr, 0);
    checkOutput("mid_rst_ldg", ldg, 4'hF);
    checkOutput("mid_rst_sxt", sxt, 4'hF);
    checkOutput("mid_rst_gnt", {f_gnt, a_gnt}, 0);
    checkOutput("mid_rst_rdy", {f_rdy, a_rdy}, 0);
    @(posedge clk); #1;
    s_rst = 1'b0; fv = 1'b0; av = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("post_rst_rot", rot, 0);
    checkOutput("post_rst_wr", wr, 0);
    @(posedge clk); #1;

    // Randomized-critical traffic from both sources: every request is eventually granted
    doReset;
    cnt_en = 1'b1;
    fork
      begin
        for (int n = 0; n < RND_N; n++) begin
          fv = 1'b1; fr = {1'($urandom_range(0, 1)), GRAM_ID_W'(n % GRAM_NB)};
          wf = 0;
          do begin
            @(negedge clk);
            wf++;
          end while (!f_rdy && wf < 400);
          if (!f_rdy) checkOutput("rnd_feed_timeout", 0, 1);
          @(posedge clk); #1;
        end
        fv = 1'b0;
      end
      begin
        for (int n = 0; n < RND_N; n++) begin
          av = 1'b1; ar = {1'($urandom_range(0, 1)), GRAM_ID_W'((n + 2) % GRAM_NB)};
          wc = 0;
          do begin
            @(negedge clk);
            wc++;
          end while (!a_rdy && wc < 400);
          if (!a_rdy) checkOutput("rnd_acc_timeout", 0, 1);
          @(posedge clk); #1;
        end
        av = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    cnt_en = 1'b0;
    checkOutput("rnd_feed_grants", feed_grants, RND_N);
    checkOutput("rnd_acc_grants", acc_grants, RND_N);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
